pc_gen: RTL and testbench

- Upstream neighbour of the fetch/decode stage in the single-cycle RV32I core.
- Holds the architectural PC register and drives it to fetch every cycle.
- Resolves the next PC from the decoder's Branch code, the ALU flags, the immediate and rs1.
- Owns run/halt/trap state and the cycle/instret counters.

---
 rtl/pc_gen_pkg.sv | 24 ++
 rtl/next_pc_calc.sv | 53 +++++
 rtl/pc_gen.sv | 114 +++++++++++
 tb/tb_pc_gen.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// Shared definitions for the PC generator and the decoder that feeds it:
// branch codes, run/halt/trap state encoding and the ebreak encoding.
package pc_gen_pkg;

  // Branch codes driven by the decoder; code 3'b011 is reserved and behaves as BR_NONE.
  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_JAL  = 3'b001;
  localparam logic [2:0] BR_JALR = 3'b010;
  localparam logic [2:0] BR_EQ   = 3'b100;
  localparam logic [2:0] BR_NE   = 3'b101;
  localparam logic [2:0] BR_LT   = 3'b110;
  localparam logic [2:0] BR_GE   = 3'b111;

  // Core execution state; HALT and TRAP are left only through reset.
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_TRAP = 2'd2
  } state_t;

  // Full instruction word of ebreak, used by the decoder to raise the ebreak strobe.
  localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC resolution: selects pc+4, pc+imm or (rs1+imm)&~1
// from the branch code and ALU flags, and flags a taken target whose bit 1 is set.
module next_pc_calc
  import pc_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      branch,
  input  logic            zero,
  input  logic            less,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);

  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] rel_pc;
  logic [XLEN-1:0] reg_pc;
  logic [XLEN-1:0] jump_pc;
  logic            taken;

  // All sums wrap modulo 2^XLEN by construction.
  assign seq_pc = pc + XLEN'(4);
  assign rel_pc = pc + imm;
  assign reg_pc = (rs1_data + imm) & ~XLEN'(1);

  // Decide whether control leaves the sequential path and where it goes.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    taken   = 1'b0;
    jump_pc = rel_pc;
    case (branch)
      BR_JAL:  taken = 1'b1;
      BR_JALR: begin
        taken   = 1'b1;
        jump_pc = reg_pc;
      end
      BR_EQ:   taken = zero;
      BR_NE:   taken = ~zero;
      BR_LT:   taken = less;
      BR_GE:   taken = ~less;
      default: taken = 1'b0;
    endcase
  end

  assign target = taken ? jump_pc : seq_pc;

  // pc+4 from an aligned pc is always aligned, so only a taken target can misalign.
  assign misaligned = taken & target[1];

endmodule

// File: rtl/pc_gen.sv
// Architectural PC register with run/halt/trap control and cycle/instret
// counters for the single-cycle RV32I core.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [2:0]      branch,
  input  logic            zero,
  input  logic            less,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_data,
  input  logic            stall,
  input  logic            ebreak,
  output logic [XLEN-1:0] pc,
  output logic            halted,
  output logic            trap,
  output logic [XLEN-1:0] trap_pc,
  output logic [XLEN-1:0] trap_tgt,
  output logic [63:0]     cycle_cnt,
  output logic [63:0]     instret_cnt
);

  state_t          state;
  state_t          state_next;
  logic [XLEN-1:0] target;
  logic            misaligned;
  logic            count_en;
  logic            retire_en;
  logic            advance_en;
  logic            capture_en;

  next_pc_calc #(.XLEN(XLEN)) u_next_pc_calc (
    .branch     (branch),
    .zero       (zero),
    .less       (less),
    .imm        (imm),
    .rs1_data   (rs1_data),
    .pc         (pc),
    .target     (target),
    .misaligned (misaligned)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is always written with non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state <= ST_RUN;
    else        state <= state_next;
  end

  // Next-state: stall masks ebreak and traps; ebreak outranks a misaligned target.
  always_comb begin
    state_next = state;
    if (state == ST_RUN && !stall) begin
      if (ebreak)          state_next = ST_HALT;
      else if (misaligned) state_next = ST_TRAP;
    end
  end

  // Outputs and datapath enables decoded from the current state and inputs.
  always_comb begin
    halted     = (state == ST_HALT);
    trap       = (state == ST_TRAP);
    count_en   = 1'b0;
    retire_en  = 1'b0;
    advance_en = 1'b0;
    capture_en = 1'b0;
    if (state == ST_RUN) begin
      count_en = 1'b1;
      if (!stall) begin
        if (ebreak) begin
          retire_en = 1'b1;
        end else if (misaligned) begin
          capture_en = 1'b1;
        end else begin
          retire_en  = 1'b1;
          advance_en = 1'b1;
        end
      end
    end
  end

  // PC register: moves only on a retiring non-ebreak instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          pc <= RESET_PC;
    else if (advance_en) pc <= target;
  end

  // Cycle and retired-instruction counters, wrapping silently at 2^64.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (count_en)  cycle_cnt   <= cycle_cnt + 64'd1;
      if (retire_en) instret_cnt <= instret_cnt + 64'd1;
    end
  end

  // Trap record: PC of the faulting jump/branch and the target it produced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_pc  <= '0;
      trap_tgt <= '0;
    end else if (capture_en) begin
      trap_pc  <= pc;
      trap_tgt <= target;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: a behavioural model compared every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_pc_gen;

  logic        clk;
  logic        rst_n;
  logic [2:0]  branch;
  logic        zero;
  logic        less;
  logic [31:0] imm;
  logic [31:0] rs1_data;
  logic        stall;
  logic        ebreak;
  logic [31:0] pc;
  logic        halted;
  logic        trap;
  logic [31:0] trap_pc;
  logic [31:0] trap_tgt;
  logic [63:0] cycle_cnt;
  logic [63:0] instret_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  pc_gen #(.XLEN(32), .RESET_PC(32'h8000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .branch      (branch),
    .zero        (zero),
    .less        (less),
    .imm         (imm),
    .rs1_data    (rs1_data),
    .stall       (stall),
    .ebreak      (ebreak),
    .pc          (pc),
    .halted      (halted),
    .trap        (trap),
    .trap_pc     (trap_pc),
    .trap_tgt    (trap_tgt),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_mode: 0 = running, 1 = halted by ebreak, 2 = stopped on misaligned target
  int          m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_trap_pc;
  logic [31:0] m_trap_tgt;
  logic [63:0] m_cycle;
  logic [63:0] m_instret;

  always @(posedge clk or negedge rst_n) begin
    logic        jumps;
    logic [31:0] dest;
    if (!rst_n) begin
      m_mode     = 0;
      m_pc       = 32'h8000_0000;
      m_trap_pc  = 0;
      m_trap_tgt = 0;
      m_cycle    = 0;
      m_instret  = 0;
    end else if (m_mode == 0) begin
      m_cycle = m_cycle + 1;
      if (stall) begin
        // nothing else happens this cycle
      end else if (ebreak) begin
        m_instret = m_instret + 1;
        m_mode    = 1;
      end else begin
        jumps = 0;
        dest  = m_pc + 4;
        if (branch == 3'd1) begin jumps = 1; dest = m_pc + imm; end
        if (branch == 3'd2) begin jumps = 1; dest = (rs1_data + imm) & 32'hFFFF_FFFE; end
        if ((branch == 3'd4 && zero) || (branch == 3'd5 && !zero) ||
            (branch == 3'd6 && less) || (branch == 3'd7 && !less)) begin
          jumps = 1;
          dest  = m_pc + imm;
        end
        if (jumps && (dest % 4) >= 2) begin
          m_trap_pc  = m_pc;
          m_trap_tgt = dest;
          m_mode     = 2;
        end else begin
          m_pc      = dest;
          m_instret = m_instret + 1;
        end
      end
    end
  end

  // Compare process: every falling edge out of reset, DUT against model.
  always @(negedge clk) begin
    if (rst_n) begin
      check("pc",       pc,          m_pc);
      check("halted",   halted,      m_mode == 1);
      check("trap",     trap,        m_mode == 2);
      check("trap_pc",  trap_pc,     m_trap_pc);
      check("trap_tgt", trap_tgt,    m_trap_tgt);
      check("cycle",    cycle_cnt,   m_cycle);
      check("instret",  instret_cnt, m_instret);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input logic [2:0] br, input logic z, input logic l,
                      input logic [31:0] im, input logic [31:0] r,
                      input logic st, input logic eb);
    branch   = br;
    zero     = z;
    less     = l;
    imm      = im;
    rs1_data = r;
    stall    = st;
    ebreak   = eb;
    @(negedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [31:0] e_pc,
                              input logic [63:0] e_cyc, input logic [63:0] e_ins);
    check({tag, ".pc"},      pc,          e_pc);
    check({tag, ".cycle"},   cycle_cnt,   e_cyc);
    check({tag, ".instret"}, instret_cnt, e_ins);
  endtask

  // Assert reset between edges and check the reset values before any clock edge.
  task automatic reset_pulse(input string tag);
    #1 rst_n = 1'b0;
    #1;
    check({tag, ".pc"},       pc,          32'h8000_0000);
    check({tag, ".halted"},   halted,      1'b0);
    check({tag, ".trap"},     trap,        1'b0);
    check({tag, ".trap_pc"},  trap_pc,     32'h0);
    check({tag, ".trap_tgt"}, trap_tgt,    32'h0);
    check({tag, ".cycle"},    cycle_cnt,   64'd0);
    check({tag, ".instret"},  instret_cnt, 64'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    branch   = 3'b000;
    zero     = 1'b0;
    less     = 1'b0;
    imm      = '0;
    rs1_data = '0;
    stall    = 1'b0;
    ebreak   = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst.pc", pc, 32'h8000_0000);
    check("rst.cycle", cycle_cnt, 64'd0);
    rst_n = 1'b1;

    // sequential fetch
    repeat (3) step(3'b000, 0, 0, 0, 0, 0, 0);
    expect_state("seq3", 32'h8000_000C, 3, 3);
    step(3'b000, 0, 0, 0, 0, 0, 0);
    // conditional branches
    step(3'b100, 1, 0, 32'hFFFF_FFF8, 0, 0, 0);
    check("beq_taken.pc", pc, 32'h8000_0008);
    repeat (2) step(3'b000, 0, 0, 0, 0, 0, 0);
    step(3'b100, 0, 0, 32'hFFFF_FFF8, 0, 0, 0);
    check("beq_not.pc", pc, 32'h8000_0014);
    step(3'b111, 0, 0, 32'd16, 0, 0, 0);
    check("bge_taken.pc", pc, 32'h8000_0024);
    // jalr clears bit 0, stays aligned
    step(3'b010, 0, 0, 32'd4, 32'h8000_0101, 0, 0);
    check("jalr.pc", pc, 32'h8000_0104);
    check("jalr.trap", trap, 1'b0);
    step(3'b101, 0, 0, 32'd8, 0, 0, 0);
    step(3'b110, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
    step(3'b011, 1, 1, 32'd100, 0, 0, 0);
    step(3'b110, 0, 0, 32'd100, 0, 0, 0);
    expect_state("mix", 32'h8000_0110, 14, 14);

    // stall holds pc and instret while a jal is presented
    repeat (4) step(3'b001, 0, 0, 32'd64, 0, 1, 0);
    expect_state("stall", 32'h8000_0110, 18, 14);
    step(3'b001, 0, 0, 32'd64, 0, 0, 0);
    expect_state("unstall", 32'h8000_0150, 19, 15);

    // stall masks ebreak, then ebreak halts
    step(3'b000, 0, 0, 0, 0, 1, 1);
    check("eb_stall.halted", halted, 1'b0);
    step(3'b000, 0, 0, 0, 0, 0, 1);
    check("ebreak.halted", halted, 1'b1);
    expect_state("ebreak", 32'h8000_0150, 21, 16);
    repeat (3) step(3'b001, 1, 1, 32'd8, 0, 0, 0);
    expect_state("halt_frozen", 32'h8000_0150, 21, 16);
    reset_pulse("rst_halt");

    // misaligned jal traps; everything freezes
    step(3'b001, 0, 0, 32'd6, 0, 0, 0);
    check("trap.trap", trap, 1'b1);
    check("trap.trap_pc", trap_pc, 32'h8000_0000);
    check("trap.trap_tgt", trap_tgt, 32'h8000_0006);
    expect_state("trap", 32'h8000_0000, 1, 0);
    for (int i = 0; i < 10; i++) step(3'(i), i[0], i[1], 32'(i * 4), 0, i[2], i[3]);
    expect_state("trap_frozen", 32'h8000_0000, 1, 0);
    check("trap_frozen.halted", halted, 1'b0);
    reset_pulse("rst_trap");

    // pc wraps modulo 2^32
    step(3'b001, 0, 0, 32'h7FFF_FFFC, 0, 0, 0);
    check("wrap_pre.pc", pc, 32'hFFFF_FFFC);
    step(3'b000, 0, 0, 0, 0, 0, 0);
    check("wrap.pc", pc, 32'h0000_0000);
    step(3'b000, 0, 0, 0, 0, 0, 0);
    // jalr target with bit 1 set traps
    step(3'b010, 0, 0, 32'd0, 32'h0000_0013, 0, 0);
    check("jalr_trap.trap", trap, 1'b1);
    check("jalr_trap.trap_pc", trap_pc, 32'h0000_0004);
    check("jalr_trap.trap_tgt", trap_tgt, 32'h0000_0012);
    expect_state("jalr_trap", 32'h0000_0004, 4, 3);
    step(3'b000, 0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
